// File: rtl/timer_pkg.sv
// Shared definitions for the push-button front end of the timer:
// key FSM state encoding, default timing constants and a counter sizing helper.
package timer_pkg;

  typedef enum logic [1:0] {
    S_ARM     = 2'd0,
    S_IDLE    = 2'd1,
    S_PRESSED = 2'd2,
    S_LONG    = 2'd3
  } keyState_t;

  // 20 ms and 2 s at a 50 MHz clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 1000000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 100000000;

  // Width of a counter that must hold values up to n-1; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-flop synchroniser, debounce counter and debounced level.
// armOk rises once the key has been seen released (through the synchroniser and
// at the debounced level) long enough to flush the reset-forced synchroniser
// values, so a key held through reset cannot look released.
module key_debounce
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic keyRaw_n,
  output logic keyDeb_n,
  output logic armOk
);

  localparam int                CNT_W      = cntWidth(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int                ARM_CYCLES = DEBOUNCE_CYCLES + 2;
  localparam int                ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0]  ARM_MAX    = ARM_W'(ARM_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] debCnt;
  logic [ARM_W-1:0] armCnt;

  // Two-flop synchroniser for the asynchronous key input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= keyRaw_n;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive disagreeing cycles; flip the debounced level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      keyDeb_n <= 1'b1;
      debCnt   <= '0;
    end else if (sync_p1 != keyDeb_n) begin
      if (debCnt == CNT_MAX) begin
        keyDeb_n <= sync_p1;
        debCnt   <= '0;
      end else begin
        debCnt <= debCnt + CNT_W'(1);
      end
    end else begin
      debCnt <= '0;
    end
  end

  // Saturating count of stable-released cycles used to leave the armed state.
  always_ff @(posedge clk) begin
    if (rst) begin
      armCnt <= '0;
    end else if (sync_p1 && keyDeb_n) begin
      if (armCnt != ARM_MAX) armCnt <= armCnt + ARM_W'(1);
    end else begin
      armCnt <= '0;
    end
  end

  assign armOk = (armCnt == ARM_MAX);

endmodule

// File: rtl/button_conditioner.sv
// Start/stop and mode push-button conditioner for the timer core.
// Each key is debounced by key_debounce and tracked by its own FSM.
// Build option LONG_PRESS_EN: start key pulses StartStop on a short-press
// release and ClearPulse once when the hold reaches LONG_PRESS_CYCLES; without
// it StartStop pulses on press and ClearPulse is constant 0.
module button_conditioner
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic CLK_50MHz,
  input  logic rst,
  input  logic KeyStart_n,
  input  logic KeyMode_n,
  output logic StartStop,
  output logic ModeSel,
  output logic ClearPulse
);

  logic      startDeb_n, startArmOk;
  logic      modeDeb_n, modeArmOk;
  keyState_t startState, startNext, startState_p1;
  keyState_t modeState, modeNext, modeState_p1;
  logic      startLong;
  logic      startEvt;
  logic      modeEvt;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uStartDeb (
    .clk      (CLK_50MHz),
    .rst      (rst),
    .keyRaw_n (KeyStart_n),
    .keyDeb_n (startDeb_n),
    .armOk    (startArmOk)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeDeb (
    .clk      (CLK_50MHz),
    .rst      (rst),
    .keyRaw_n (KeyMode_n),
    .keyDeb_n (modeDeb_n),
    .armOk    (modeArmOk)
  );

`ifdef LONG_PRESS_EN
  localparam int                LONG_W   = cntWidth(LONG_PRESS_CYCLES);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_PRESS_CYCLES - 1);

  logic [LONG_W-1:0] longCnt;
  logic              clearEvt;

  // Hold-time counter; runs only while the start key stays in S_PRESSED.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      longCnt <= '0;
    end else if (startState == S_PRESSED && startNext == S_PRESSED) begin
      longCnt <= longCnt + LONG_W'(1);
    end else begin
      longCnt <= '0;
    end
  end

  assign startLong = (longCnt == LONG_MAX);
`else
  assign startLong = 1'b0;
`endif

  // State registers; the _p1 copies let the output logic see each transition.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      startState    <= S_ARM;
      startState_p1 <= S_ARM;
      modeState     <= S_ARM;
      modeState_p1  <= S_ARM;
    end else begin
      startState    <= startNext;
      startState_p1 <= startState;
      modeState     <= modeNext;
      modeState_p1  <= modeState;
    end
  end

  // Next-state logic; release has priority over the long-press threshold.
  always_comb begin
    startNext = startState;
    case (startState)
      S_ARM:     if (startArmOk) startNext = S_IDLE;
      S_IDLE:    if (!startDeb_n) startNext = S_PRESSED;
      S_PRESSED: if (startDeb_n) startNext = S_IDLE;
                 else if (startLong) startNext = S_LONG;
      S_LONG:    if (startDeb_n) startNext = S_IDLE;
      default:   startNext = S_ARM;
    endcase

    modeNext = modeState;
    case (modeState)
      S_ARM:     if (modeArmOk) modeNext = S_IDLE;
      S_IDLE:    if (!modeDeb_n) modeNext = S_PRESSED;
      S_PRESSED: if (modeDeb_n) modeNext = S_IDLE;
      default:   modeNext = S_IDLE;
    endcase
  end

  // Output events decoded from the transition just taken.
  always_comb begin
`ifdef LONG_PRESS_EN
    startEvt = (startState_p1 == S_PRESSED) && (startState == S_IDLE);
    clearEvt = (startState_p1 == S_PRESSED) && (startState == S_LONG);
`else
    startEvt = (startState_p1 == S_IDLE) && (startState == S_PRESSED);
`endif
    modeEvt  = (modeState_p1 == S_IDLE) && (modeState == S_PRESSED);
  end

  // Registered outputs toward the timer core.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) begin
      StartStop <= 1'b0;
      ModeSel   <= 1'b0;
    end else begin
      StartStop <= startEvt;
      ModeSel   <= ModeSel ^ modeEvt;
    end
  end

`ifdef LONG_PRESS_EN
  // Clear request register.
  always_ff @(posedge CLK_50MHz) begin
    if (rst) ClearPulse <= 1'b0;
    else     ClearPulse <= clearEvt;
  end
`else
  assign ClearPulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20).
// Reference model: a key's debounced level flips once its last DB synchronised
// samples all disagree with it; outputs follow two edges after the deciding edge.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int LP = 20;

  logic clk = 1'b0;
  logic rst;
  logic KeyStart_n;
  logic KeyMode_n;
  logic StartStop;
  logic ModeSel;
  logic ClearPulse;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut (
    .CLK_50MHz  (clk),
    .rst        (rst),
    .KeyStart_n (KeyStart_n),
    .KeyMode_n  (KeyMode_n),
    .StartStop  (StartStop),
    .ModeSel    (ModeSel),
    .ClearPulse (ClearPulse)
  );

  int vectors = 0;
  int miscompares = 0;
  int n = 0;

  // observation statistics
  int   startCount, clearCount, toggles;
  int   lastStart, lastClear, lastToggle;
  logic prevStart = 1'b0, prevClear = 1'b0, prevMode = 1'b0;

  // reference model state
  bit   modelOn = 0;
  logic hS[$];
  logic hM[$];
  logic debS, debM, expMode;
  bit   sHeld, sLong;
  int   sPressAt;
  int   qS[$];
  int   qC[$];
  int   qM[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // True when the DB most recent synchronised samples (raw delayed two edges) all differ from deb.
  function automatic bit flips(input logic hist[$], input logic deb);
    for (int i = 2; i <= DB + 1; i++)
      if (hist[hist.size() - 1 - i] == deb) return 0;
    return 1;
  endfunction

  task automatic modelRestart();
    hS.delete(); hM.delete(); qS.delete(); qC.delete(); qM.delete();
    for (int i = 0; i < 16; i++) begin hS.push_back(1'b1); hM.push_back(1'b1); end
    debS = 1'b1; debM = 1'b1; expMode = 1'b0;
    sHeld = 0; sLong = 0; sPressAt = 0;
    modelOn = 1;
  endtask

  task automatic modelEdge(input logic s, input logic m);
    hS.push_back(s); hM.push_back(m);
    if (hS.size() > 16) void'(hS.pop_front());
    if (hM.size() > 16) void'(hM.pop_front());
`ifdef LONG_PRESS_EN
    if (sHeld && !sLong && n == sPressAt + LP + 1) begin
      sLong = 1;
      qC.push_back(n + 1);
    end
`endif
    if (flips(hS, debS)) begin
      debS = !debS;
`ifdef LONG_PRESS_EN
      if (!debS) begin
        sHeld = 1; sLong = 0; sPressAt = n;
      end else begin
        if (sHeld && !sLong) qS.push_back(n + 2);
        sHeld = 0;
      end
`else
      if (!debS) qS.push_back(n + 2);
`endif
    end
    if (flips(hM, debM)) begin
      debM = !debM;
      if (!debM) qM.push_back(n + 2);
    end
  endtask

  task automatic clearStats();
    startCount = 0; clearCount = 0; toggles = 0;
    lastStart = -1; lastClear = -1; lastToggle = -1;
  endtask

  // One clock: drive keys, let the edge happen, then observe on the falling edge.
  task automatic step(input logic s, input logic m);
    logic expS, expC;
    KeyStart_n = s;
    KeyMode_n  = m;
    @(posedge clk);
    n++;
    if (modelOn) modelEdge(s, m);
    @(negedge clk);
    if (modelOn) begin
      expS = 1'b0;
      expC = 1'b0;
      if (qS.size() > 0 && qS[0] == n) begin expS = 1'b1; void'(qS.pop_front()); end
      if (qC.size() > 0 && qC[0] == n) begin expC = 1'b1; void'(qC.pop_front()); end
      if (qM.size() > 0 && qM[0] == n) begin expMode = !expMode; void'(qM.pop_front()); end
      check("model StartStop", StartStop, expS);
      check("model ClearPulse", ClearPulse, expC);
      check("model ModeSel", ModeSel, expMode);
    end
    if (StartStop === 1'b1) begin startCount++; lastStart = n; end
    if (ClearPulse === 1'b1) begin clearCount++; lastClear = n; end
    if (ModeSel !== prevMode) begin toggles++; lastToggle = n; end
    check("StartStop/ClearPulse overlap", StartStop & ClearPulse, 0);
    check("StartStop two cycles", prevStart & StartStop, 0);
    check("ClearPulse two cycles", prevClear & ClearPulse, 0);
    prevStart = StartStop;
    prevClear = ClearPulse;
    prevMode  = ModeSel;
  endtask

  task automatic applyReset(input logic s, input logic m, input int cycles);
    modelOn = 0;
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step(s, m);
      check("reset StartStop", StartStop, 0);
      check("reset ModeSel", ModeSel, 0);
      check("reset ClearPulse", ClearPulse, 0);
    end
    rst = 1'b0;
  endtask

  task automatic freshStart();
    applyReset(1'b1, 1'b1, 3);
    modelRestart();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
  endtask

  int f;
  int remS, remM;
  logic levS, levM;

  initial begin
    rst = 1'b1;
    KeyStart_n = 1'b1;
    KeyMode_n  = 1'b1;

    // Clean start press
    freshStart();
    clearStats();
    f = n + 1;
`ifdef LONG_PRESS_EN
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    check("short press StartStop count", startCount, 1);
    check("short press release latency", lastStart - f, 15);
    check("short press ClearPulse count", clearCount, 0);

    // Long hold
    freshStart();
    clearStats();
    f = n + 1;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    check("long hold ClearPulse while held", clearCount, 1);
    check("long hold ClearPulse time", lastClear - f, 27);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
    check("long hold ClearPulse count", clearCount, 1);
    check("long hold no StartStop", startCount, 0);
`else
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    check("press StartStop count", startCount, 1);
    check("press latency", lastStart - f, 7);
    check("press ClearPulse count", clearCount, 0);
`endif
    check("press no mode toggle", toggles, 0);

    // Mode key bounce then clean presses, twice
    freshStart();
    clearStats();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
      if (r == 0) check("mode after first press", ModeSel, 1);
    end
    check("mode toggle count", toggles, 2);
    check("mode final level", ModeSel, 0);
    check("mode no StartStop", startCount, 0);

    // Both keys held through reset release
    applyReset(1'b0, 1'b0, 3);
    clearStats();
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("held through reset StartStop", startCount, 0);
    check("held through reset ModeSel", toggles, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("re-press StartStop count", startCount, 1);
    check("re-press mode toggle count", toggles, 1);
`ifndef LONG_PRESS_EN
    check("re-press same cycle", lastStart, lastToggle);
`endif

    // Reset in the middle of a debounce
    freshStart();
    clearStats();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    applyReset(1'b0, 1'b0, 1);
    modelRestart();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("mid-debounce reset StartStop", startCount, 0);
    check("mid-debounce reset ModeSel", toggles, 0);
    check("mid-debounce reset ClearPulse", clearCount, 0);

    // Randomised run lengths on both keys against the model
    freshStart();
    remS = 0; remM = 0; levS = 1'b1; levM = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (remS == 0) begin levS = 1'($urandom_range(0, 1)); remS = $urandom_range(1, 30); end
      if (remM == 0) begin levM = 1'($urandom_range(0, 1)); remM = $urandom_range(1, 30); end
      remS--; remM--;
      step(levS, levM);
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("random queue StartStop drained", qS.size(), 0);
    check("random queue mode drained", qM.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of stable clock cycles required to accept a key level change (20 ms at 50 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 100000000, is the debounced hold time on KeyStart that qualifies as a long press (2 s).
REQ-003 CLK_50MHz  input  1  is the single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset.
REQ-005 KeyStart_n  input  1  is the raw, asynchronous, active-low start/stop push-button.
REQ-006 KeyMode_n  input  1  is the raw, asynchronous, active-low mode push-button.
REQ-007 StartStop  output  1  is a one-cycle pulse toward the timer core.
REQ-008 ModeSel  output  1  is a level toward the timer core (0 = stopwatch, 1 = countdown).
REQ-009 ClearPulse  output  1  is a one-cycle pulse requesting a timer clear.

Function
REQ-010 Each key SHALL pass through a 2-flop synchroniser before any other logic.
REQ-011 Debounce: the counter SHALL increment on each cycle that the synced level differs from the debounced level, and clear to 0 on any cycle they match.
REQ-012 The debounced level SHALL flip on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL then clear.
REQ-013 Counter width SHALL be $clog2(DEBOUNCE_CYCLES) and SHALL never wrap; the same rule applies to the long-press counter with its own parameter.
REQ-014 A key glitch shorter than DEBOUNCE_CYCLES SHALL produce no output change.
REQ-015 Per-key FSM states SHALL be S_ARM, S_IDLE, S_PRESSED and S_LONG.
REQ-016 S_ARM: go to S_IDLE once the debounced level is released; never emit output from S_ARM.
REQ-017 S_IDLE: a debounced press goes to S_PRESSED.
REQ-018 S_PRESSED: a debounced release goes to S_IDLE; reaching the long-press threshold goes to S_LONG.
REQ-019 S_LONG: a debounced release goes to S_IDLE.
REQ-020 Mode key: each S_IDLE to S_PRESSED transition SHALL toggle ModeSel one cycle later; the mode key has no long-press behaviour.
REQ-021 Start key press latency: the output pulse SHALL be high exactly DEBOUNCE_CYCLES+3 cycles after the first edge that samples the key stably active.
REQ-022 Both keys are independent; simultaneous events SHALL allow StartStop and a ModeSel toggle in the same cycle.
REQ-023 StartStop and ClearPulse SHALL never both be high in the same cycle and SHALL never stay high for two consecutive cycles.

Reset
REQ-024 While rst is high, on each clock edge:
- StartStop, ClearPulse and ModeSel SHALL be 0.
- Synchroniser flops SHALL be 1.
- Debounced levels SHALL be released.
- All counters SHALL be 0.
- Both FSMs SHALL be in S_ARM.
REQ-025 A key held through reset deassertion SHALL generate no pulse or toggle until it is released stably and pressed again.
REQ-026 Reset mid-debounce or mid-hold SHALL discard the partial count.

Configuration
REQ-027 Macro LONG_PRESS_EN defined: StartStop SHALL pulse on debounced release from S_PRESSED only.
REQ-028 Macro LONG_PRESS_EN defined: ClearPulse SHALL pulse once on S_PRESSED to S_LONG, and release from S_LONG SHALL emit nothing.
REQ-029 Macro LONG_PRESS_EN undefined: StartStop SHALL pulse on S_IDLE to S_PRESSED and S_LONG SHALL be unreachable.
REQ-030 Macro LONG_PRESS_EN undefined: ClearPulse SHALL be tied to 0 and the long-press counter SHALL be omitted; the port list SHALL be unchanged.

Structure
REQ-031 Package timer_pkg SHALL hold the key FSM state enum and the default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants.
REQ-032 Sub-module key_debounce (synchroniser plus debounce counter plus debounced level output) SHALL be instantiated once per key; the FSMs and outputs live in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-033 Clean KeyStart_n low for 10 cycles with LONG_PRESS_EN undefined -> StartStop is high exactly 1 cycle, 7 cycles after the first low sample; ModeSel and ClearPulse stay 0.
REQ-034 KeyMode_n bounces low for 2 cycles, then low stable for 6, then high for 6, repeated twice -> ModeSel goes 0 to 1 to 0; bounce segments cause no toggle.
REQ-035 LONG_PRESS_EN defined, KeyStart_n low for 8 cycles then released -> a single StartStop pulse after release debounce; ClearPulse stays 0.
REQ-036 LONG_PRESS_EN defined, KeyStart_n low for 40 cycles -> exactly one ClearPulse while held; no StartStop on release.
REQ-037 Both keys held low through rst deassertion, then released, then pressed together -> no output until the re-press; then StartStop and the ModeSel toggle occur in the same cycle.
REQ-038 rst pulsed mid-debounce (key low for 2 cycles) -> outputs remain 0 and no delayed pulse appears after reset.
